// File: rtl/mesh_bridge_pkg.sv
// Shared header layout and field helpers for the mesh terminal bridge.
// Header (MSB first): next-jump, target row, target column, mode, payload.
package mesh_bridge_pkg;

    localparam int unsigned NxtJmpW = 8;
    localparam int unsigned RowColW = 4;
    localparam int unsigned TgtW    = 2 * RowColW;

    typedef struct packed {
        logic [RowColW-1:0] row;
        logic [RowColW-1:0] col;
    } tgt_t;

    // Takes the row/col byte that sits directly below the next-jump field.
    function automatic tgt_t tgt_of(input logic [TgtW-1:0] rc);
        tgt_t t;
        t.row = rc[TgtW-1 -: RowColW];
        t.col = rc[RowColW-1:0];
        return t;
    endfunction

endpackage

// File: rtl/bridge_fifo.sv
// Synchronous FIFO with head-visible read data; push on full is accepted only with a pop,
// pop on empty is ignored.
module bridge_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));
    assign count_o = count_q;
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: reads are masked by the empty flag.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mesh_terminal_bridge.sv
// Bridges host packet sources/sinks to every mesh_gnrtr terminal: per-channel injection and
// ejection FIFOs, injection gating, destination checking, saturating stats, protocol errors.
module mesh_terminal_bridge
    import mesh_bridge_pkg::*;
#(
    parameter int unsigned NUM_TERM   = 16,
    parameter int unsigned PAKG_SIZE  = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_TERM-1:0]                  host_push,
    input  logic [NUM_TERM-1:0][PAKG_SIZE-1:0]   host_wdata,
    output logic [NUM_TERM-1:0]                  inj_full,
    input  logic [NUM_TERM-1:0]                  inj_en,
    output logic [NUM_TERM-1:0]                  pndng_i_in,
    output logic [NUM_TERM-1:0][PAKG_SIZE-1:0]   data_out_i_in,
    input  logic [NUM_TERM-1:0]                  popin,
    input  logic [NUM_TERM-1:0]                  pndng,
    input  logic [NUM_TERM-1:0][PAKG_SIZE-1:0]   data_out,
    output logic [NUM_TERM-1:0]                  pop,
    input  logic [NUM_TERM-1:0]                  host_pop,
    output logic [NUM_TERM-1:0][PAKG_SIZE-1:0]   host_rdata,
    output logic [NUM_TERM-1:0]                  ej_valid,
    input  logic [NUM_TERM-1:0][3:0]             my_row,
    input  logic [NUM_TERM-1:0][3:0]             my_col,
    input  logic                                 cnt_clr,
    output logic [NUM_TERM-1:0][CNT_W-1:0]       inj_cnt,
    output logic [NUM_TERM-1:0][CNT_W-1:0]       ej_cnt,
    output logic [NUM_TERM-1:0][CNT_W-1:0]       misroute_cnt,
    output logic [NUM_TERM-1:0]                  proto_err
);
    localparam int unsigned     FCntW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CntMax = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        return (inc && cnt != CntMax) ? cnt + CNT_W'(1) : cnt;
    endfunction

    for (genvar ch = 0; ch < NUM_TERM; ch++) begin : g_ch
        logic             inj_empty, inj_pop, ej_full, ej_empty, ej_push, misroute;
        logic [FCntW-1:0] inj_count, ej_count;
        tgt_t             tgt;
        logic [CNT_W-1:0] inj_cnt_q, inj_cnt_d, ej_cnt_q, ej_cnt_d, mis_cnt_q, mis_cnt_d;
        logic             proto_err_q, proto_err_d;

        assign pndng_i_in[ch] = inj_en[ch] & ~inj_empty;
        assign inj_pop        = popin[ch] & pndng_i_in[ch];

        bridge_fifo #(
            .WIDTH (PAKG_SIZE),
            .DEPTH (FIFO_DEPTH)
        ) u_inj_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_i),
            .push_i  (host_push[ch]),
            .wdata_i (host_wdata[ch]),
            .pop_i   (inj_pop),
            .rdata_o (data_out_i_in[ch]),
            .full_o  (inj_full[ch]),
            .empty_o (inj_empty),
            .count_o (inj_count)
        );

        // Registered full only, so a same-cycle host_pop never opens a slot for the mesh.
        assign ej_push  = pndng[ch] & ~ej_full & rst_i;
        assign pop[ch]  = ej_push;
        assign ej_valid[ch] = ~ej_empty;

        bridge_fifo #(
            .WIDTH (PAKG_SIZE),
            .DEPTH (FIFO_DEPTH)
        ) u_ej_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_i),
            .push_i  (ej_push),
            .wdata_i (data_out[ch]),
            .pop_i   (host_pop[ch]),
            .rdata_o (host_rdata[ch]),
            .full_o  (ej_full),
            .empty_o (ej_empty),
            .count_o (ej_count)
        );

        assign tgt      = tgt_of(data_out[ch][PAKG_SIZE-1-NxtJmpW -: TgtW]);
        assign misroute = (tgt.row != my_row[ch]) | (tgt.col != my_col[ch]);

        always_comb begin
            inj_cnt_d   = sat_inc(inj_cnt_q, inj_pop);
            ej_cnt_d    = sat_inc(ej_cnt_q, ej_push);
            mis_cnt_d   = sat_inc(mis_cnt_q, ej_push & misroute);
            proto_err_d = proto_err_q | (popin[ch] & ~pndng_i_in[ch]);
            if (cnt_clr) begin
                inj_cnt_d   = '0;
                ej_cnt_d    = '0;
                mis_cnt_d   = '0;
                proto_err_d = 1'b0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                inj_cnt_q   <= '0;
                ej_cnt_q    <= '0;
                mis_cnt_q   <= '0;
                proto_err_q <= 1'b0;
            end else begin
                inj_cnt_q   <= inj_cnt_d;
                ej_cnt_q    <= ej_cnt_d;
                mis_cnt_q   <= mis_cnt_d;
                proto_err_q <= proto_err_d;
            end
        end

        assign inj_cnt[ch]      = inj_cnt_q;
        assign ej_cnt[ch]       = ej_cnt_q;
        assign misroute_cnt[ch] = mis_cnt_q;
        assign proto_err[ch]    = proto_err_q;

        a_inj_count: assert property (@(posedge clk_i) disable iff (!rst_i)
            inj_count <= FCntW'(FIFO_DEPTH));
        a_ej_count: assert property (@(posedge clk_i) disable iff (!rst_i)
            ej_count <= FCntW'(FIFO_DEPTH));
    end

endmodule
